// File: rtl/regfile_mp_if.sv
// Bus bundle between issue/writeback logic (master) and the multi-port register file (slave).
interface regfile_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 4
);
  logic                      ready;
  logic                      we0;
  logic [ADDR_W-1:0]         waddr0;
  logic [DATA_W-1:0]         wdata0;
  logic                      we1;
  logic [ADDR_W-1:0]         waddr1;
  logic [DATA_W-1:0]         wdata1;
  logic [NUM_RD*ADDR_W-1:0]  raddr;
  logic [NUM_RD*DATA_W-1:0]  rdata;
  logic                      sb_set_en;
  logic [ADDR_W-1:0]         sb_set_addr;
  logic [NUM_RD-1:0]         rd_pending;

  modport master (
    input  ready, rdata, rd_pending,
    output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, sb_set_en, sb_set_addr
  );

  modport slave (
    output ready, rdata, rd_pending,
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, sb_set_en, sb_set_addr
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports with bypass,
// hardwired zero register, pending-write scoreboard and a post-reset clear sweep.
module regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 4
) (
  input  logic          clk,
  input  logic          rst,
  regfile_mp_if.slave   bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_e;

  state_e                   state_q;
  logic [ADDR_W-1:0]        cnt_q;
  logic                     ready_q;
  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DEPTH-1:0]         pending_q;
  logic [DEPTH-1:0]         pending_d;
  logic                     wr0;
  logic                     wr1;
  logic [NUM_RD*DATA_W-1:0] rdata_d;
  logic [NUM_RD-1:0]        rd_pending_d;
  logic [ADDR_W-1:0]        ra;
  logic                     hit0;
  logic                     hit1;

  // Writes to register 0 are dropped here, so every consumer can treat wr0/wr1 as real commits.
  assign wr0 = ready_q && bus.we0 && (bus.waddr0 != '0);
  assign wr1 = ready_q && bus.we1 && (bus.waddr1 != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= ADDR_W'(1);
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= S_READY;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        S_READY: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_CLEAR;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; the sweep zeroes it. Port 1 is written last so it wins on a collision.
  always_ff @(posedge clk) begin
    if (!ready_q) begin
      mem_q[cnt_q] <= '0;
    end else if (!rst) begin
      if (wr0) mem_q[bus.waddr0] <= bus.wdata0;
      if (wr1) mem_q[bus.waddr1] <= bus.wdata1;
    end
  end

  // Set is applied after clear so a newly issued producer overrides a retiring one.
  always_comb begin
    pending_d = pending_q;
    if (ready_q) begin
      if (wr0) pending_d[bus.waddr0] = 1'b0;
      if (wr1) pending_d[bus.waddr1] = 1'b0;
      if (bus.sb_set_en) pending_d[bus.sb_set_addr] = 1'b1;
    end else begin
      pending_d = '0;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_comb begin
    rdata_d      = '0;
    rd_pending_d = '0;
    ra           = '0;
    hit0         = 1'b0;
    hit1         = 1'b0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra   = bus.raddr[i*ADDR_W +: ADDR_W];
      hit0 = wr0 && (bus.waddr0 == ra);
      hit1 = wr1 && (bus.waddr1 == ra);
      if (ready_q && (ra != '0)) begin
        if (hit1) begin
          rdata_d[i*DATA_W +: DATA_W] = bus.wdata1;
        end else if (hit0) begin
          rdata_d[i*DATA_W +: DATA_W] = bus.wdata0;
        end else begin
          rdata_d[i*DATA_W +: DATA_W] = mem_q[ra];
        end
        rd_pending_d[i] = pending_q[ra] && !(hit0 || hit1);
      end
    end
  end

  assign bus.ready      = ready_q;
  assign bus.rdata      = rdata_d;
  assign bus.rd_pending = rd_pending_d;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a 4-port/32-entry build and an 8-port/16-entry build.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4)) b0 ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(8)) b1 ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  regfile_mp #(.DATA_W(32), .ADDR_W(4), .NUM_RD(8)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  typedef struct {
    int          dut;
    int          kind;   // 0 rdata, 1 rd_pending, 2 ready
    int          port;
    logic [31:0] exp;
    int          tag;
  } exp_t;

  exp_t sbq[$];
  event chk_ev;
  int   tests = 0;
  int   fails = 0;

  function automatic logic [31:0] act_of(exp_t e);
    if (e.dut == 0) begin
      case (e.kind)
        0:       return b0.rdata[e.port*32 +: 32];
        1:       return {31'b0, b0.rd_pending[e.port]};
        default: return {31'b0, b0.ready};
      endcase
    end else begin
      case (e.kind)
        0:       return b1.rdata[e.port*32 +: 32];
        1:       return {31'b0, b1.rd_pending[e.port]};
        default: return {31'b0, b1.ready};
      endcase
    end
  endfunction

  // Monitor: drains every expectation queued for the current sample point.
  initial begin
    exp_t        e;
    logic [31:0] act;
    string       kn;
    forever begin
      @(chk_ev);
      #1;
      while (sbq.size() > 0) begin
        e   = sbq.pop_front();
        act = act_of(e);
        kn  = (e.kind == 0) ? "rdata" : (e.kind == 1) ? "rd_pending" : "ready";
        tests++;
        if (act !== e.exp) begin
          fails++;
          $display("FAIL tag%0d dut%0d %s[%0d]: got %h expected %h", e.tag, e.dut, kn, e.port, act, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic idle();
    b0.we0 = 1'b0; b0.waddr0 = '0; b0.wdata0 = '0;
    b0.we1 = 1'b0; b0.waddr1 = '0; b0.wdata1 = '0;
    b0.sb_set_en = 1'b0; b0.sb_set_addr = '0;
    b1.we0 = 1'b0; b1.waddr0 = '0; b1.wdata0 = '0;
    b1.we1 = 1'b0; b1.waddr1 = '0; b1.wdata1 = '0;
    b1.sb_set_en = 1'b0; b1.sb_set_addr = '0;
  endtask

  task automatic push(input int d, input int k, input int p, input logic [31:0] v, input int tag);
    exp_t e;
    e.dut = d; e.kind = k; e.port = p; e.exp = v; e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic rd(input int d, input int p, input int a, input logic [31:0] v, input int tag);
    if (d == 0) b0.raddr[p*5 +: 5] = 5'(a);
    else        b1.raddr[p*4 +: 4] = 4'(a);
    push(d, 0, p, v, tag);
  endtask

  task automatic pd(input int d, input int p, input logic v, input int tag);
    push(d, 1, p, {31'b0, v}, tag);
  endtask

  task automatic fire();
    ->chk_ev;
    #2;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic direct(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    int          n;
    int          n0;
    int          n1;
    logic [31:0] v1 [8];
    v1 = '{32'h0000_0011, 32'h1234_5678, 32'hCAFE_BABE, 32'h8000_0001,
           32'h0F0F_0F0F, 32'hFFFF_FFFE, 32'h7654_3210, 32'hA0A0_0B0B};

    rst = 1'b1;
    idle();
    b0.raddr = '0;
    b1.raddr = '0;

    // Reset state
    tick();
    rd(0, 0, 1, 32'h0, 1); rd(0, 1, 5, 32'h0, 1);
    pd(0, 0, 1'b0, 1); pd(0, 1, 1'b0, 1);
    push(0, 2, 0, 32'h0, 1); push(1, 2, 0, 32'h0, 1);
    rd(1, 7, 3, 32'h0, 1);
    fire();
    rst = 1'b0;

    // Sweep length for both builds
    n = 0; n0 = 0; n1 = 0;
    while ((!b0.ready || !b1.ready) && n < 100) begin
      tick();
      n++;
      if (b0.ready && n0 == 0) n0 = n;
      if (b1.ready && n1 == 0) n1 = n;
    end
    direct("sweep_len_32", n0, 31);
    direct("sweep_len_16", n1, 15);

    for (int a = 0; a < 32; a += 4) begin
      tick();
      for (int p = 0; p < 4; p++) rd(0, p, a + p, 32'h0, 2);
      fire();
    end
    for (int a = 0; a < 16; a += 8) begin
      tick();
      for (int p = 0; p < 8; p++) rd(1, p, a + p, 32'h0, 2);
      fire();
    end

    // Bypass then storage
    tick(); b0.we0 = 1'b1; b0.waddr0 = 5'd5; b0.wdata0 = 32'hDEAD_BEEF;
    rd(0, 2, 5, 32'hDEAD_BEEF, 3); pd(0, 2, 1'b0, 3); fire();
    tick(); idle(); rd(0, 2, 5, 32'hDEAD_BEEF, 4); fire();

    // Same-address collision: port 1 wins
    tick(); b0.we0 = 1'b1; b0.waddr0 = 5'd7; b0.wdata0 = 32'h1111_1111;
    b0.we1 = 1'b1; b0.waddr1 = 5'd7; b0.wdata1 = 32'h2222_2222;
    rd(0, 0, 7, 32'h2222_2222, 5); fire();
    tick(); idle(); rd(0, 0, 7, 32'h2222_2222, 6); fire();

    // Register 0 stays zero
    tick(); b0.we0 = 1'b1; b0.waddr0 = 5'd0; b0.wdata0 = 32'hFFFF_FFFF;
    b0.we1 = 1'b1; b0.waddr1 = 5'd0; b0.wdata1 = 32'h1234_5678;
    rd(0, 1, 0, 32'h0, 7); fire();
    tick(); idle(); rd(0, 1, 0, 32'h0, 8); fire();

    // Independent ports, both write ports to distinct addresses
    tick(); b0.we0 = 1'b1; b0.waddr0 = 5'd10; b0.wdata0 = 32'hA5A5_A5A5;
    b0.we1 = 1'b1; b0.waddr1 = 5'd11; b0.wdata1 = 32'h5A5A_5A5A;
    rd(0, 0, 10, 32'hA5A5_A5A5, 9); rd(0, 1, 11, 32'h5A5A_5A5A, 9);
    rd(0, 2, 7, 32'h2222_2222, 9); rd(0, 3, 5, 32'hDEAD_BEEF, 9); fire();
    tick(); idle();
    rd(0, 0, 10, 32'hA5A5_A5A5, 10); rd(0, 1, 11, 32'h5A5A_5A5A, 10);
    rd(0, 2, 7, 32'h2222_2222, 10); rd(0, 3, 5, 32'hDEAD_BEEF, 10); fire();

    // Scoreboard
    tick(); b0.sb_set_en = 1'b1; b0.sb_set_addr = 5'd9;
    rd(0, 3, 9, 32'h0, 11); pd(0, 3, 1'b0, 11); fire();
    tick(); idle();
    rd(0, 0, 9, 32'h0, 12); pd(0, 0, 1'b1, 12); pd(0, 3, 1'b1, 12); fire();
    tick(); b0.we0 = 1'b1; b0.waddr0 = 5'd9; b0.wdata0 = 32'h0000_0099;
    rd(0, 1, 9, 32'h0000_0099, 13); pd(0, 0, 1'b0, 13); pd(0, 1, 1'b0, 13); pd(0, 3, 1'b0, 13); fire();
    tick(); idle();
    rd(0, 0, 9, 32'h0000_0099, 14); pd(0, 0, 1'b0, 14); pd(0, 1, 1'b0, 14); pd(0, 3, 1'b0, 14); fire();
    tick(); b0.sb_set_en = 1'b1; b0.sb_set_addr = 5'd9;
    b0.we1 = 1'b1; b0.waddr1 = 5'd9; b0.wdata1 = 32'h0000_00AA;
    pd(0, 0, 1'b0, 15); rd(0, 1, 9, 32'h0000_00AA, 15); fire();
    tick(); idle(); pd(0, 0, 1'b1, 16); rd(0, 0, 9, 32'h0000_00AA, 16); fire();
    tick(); b0.sb_set_en = 1'b1; b0.sb_set_addr = 5'd0;
    b0.we0 = 1'b1; b0.waddr0 = 5'd9; b0.wdata0 = 32'h0000_00BB;
    pd(0, 0, 1'b0, 17); rd(0, 2, 0, 32'h0, 17); pd(0, 2, 1'b0, 17); fire();
    tick(); idle(); pd(0, 0, 1'b0, 18); pd(0, 2, 1'b0, 18); fire();
    tick(); b0.sb_set_en = 1'b1; b0.sb_set_addr = 5'd12;
    tick(); idle(); rd(0, 3, 12, 32'h0, 19); pd(0, 3, 1'b1, 19); fire();

    // Reset mid-sweep restarts the sweep; CLEAR ignores writes and sb_set
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    repeat (10) tick();
    push(0, 2, 0, 32'h0, 20); rd(0, 1, 11, 32'h0, 20); fire();
    rst = 1'b1;
    tick(); rst = 1'b0;
    b0.we0 = 1'b1; b0.waddr0 = 5'd5;  b0.wdata0 = 32'h5555_5555;
    b0.we1 = 1'b1; b0.waddr1 = 5'd11; b0.wdata1 = 32'h6666_6666;
    b0.sb_set_en = 1'b1; b0.sb_set_addr = 5'd12;
    rd(0, 0, 5, 32'h0, 21); rd(0, 3, 12, 32'h0, 21); pd(0, 3, 1'b0, 21);
    push(0, 2, 0, 32'h0, 21); fire();
    n0 = 0;
    while (!b0.ready && n0 < 100) begin
      tick();
      n0++;
    end
    idle();
    direct("resweep_len", n0, 31);
    for (int a = 0; a < 32; a += 4) begin
      tick();
      for (int p = 0; p < 4; p++) begin
        rd(0, p, a + p, 32'h0, 22);
        pd(0, p, 1'b0, 22);
      end
      fire();
    end

    // 8-port build: fill 1..8, read all ports at once
    for (int k = 0; k < 4; k++) begin
      tick();
      b1.we0 = 1'b1; b1.waddr0 = 4'(2*k + 1); b1.wdata0 = v1[2*k];
      b1.we1 = 1'b1; b1.waddr1 = 4'(2*k + 2); b1.wdata1 = v1[2*k + 1];
    end
    tick(); idle();
    for (int p = 0; p < 8; p++) rd(1, p, p + 1, v1[p], 23);
    fire();
    tick(); b1.we0 = 1'b1; b1.waddr0 = 4'd3; b1.wdata0 = 32'hC0FF_EE00;
    b1.we1 = 1'b1; b1.waddr1 = 4'd3; b1.wdata1 = 32'h0BAD_F00D;
    rd(1, 2, 3, 32'h0BAD_F00D, 24); rd(1, 0, 1, v1[0], 24); rd(1, 5, 3, 32'h0BAD_F00D, 24); fire();
    tick(); idle(); rd(1, 2, 3, 32'h0BAD_F00D, 25); rd(1, 5, 6, v1[5], 25); fire();

    tick();
    direct("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
